// File: rtl/res_scan_pkg.sv
// Shared definitions for the ResNet scan controllers: state encoding and the
// configuration legality rule applied when a scan is started.
package res_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_HSYNC = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_t;

  // Strides must tile the map exactly because the last-position test is an equality.
  function automatic logic cfg_legal(
    input logic [31:0] width,
    input logic [31:0] height,
    input logic [31:0] channel,
    input logic [31:0] step_x,
    input logic [31:0] step_y,
    input logic [31:0] n_ch_par
  );
    logic ok;
    ok = (channel != 32'd0) && ((channel & (n_ch_par - 32'd1)) == 32'd0) &&
         (step_x != 32'd0) && (step_y != 32'd0) &&
         (width >= step_x) && (height >= step_y);
    if (ok) begin
      ok = (((width - step_x) % step_x) == 32'd0) &&
           (((height - step_y) % step_y) == 32'd0);
    end
    return ok;
  endfunction

endpackage

// File: rtl/res_scan_pos.sv
// Stallable nested channel-group / column / row position counter with the
// end-of-line and end-of-frame decodes and the per-frame pixel count.
module res_scan_pos
  import res_scan_pkg::*;
#(
  parameter int W_SIZE       = 8,
  parameter int W_FRAME_SIZE = 2*W_SIZE+3,
  parameter int N_CH_PAR     = 1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_adv,
  input  logic [W_SIZE-1:0]       i_width,
  input  logic [W_SIZE-1:0]       i_height,
  input  logic [W_SIZE-1:0]       i_channel,
  input  logic [W_SIZE-1:0]       i_step_x,
  input  logic [W_SIZE-1:0]       i_step_y,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_SIZE-1:0]       o_chn,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_line,
  output logic                    o_end_frame
);

  localparam logic [W_SIZE:0] CH_INC = (W_SIZE+1)'(N_CH_PAR);

  logic [W_SIZE-1:0]       r_row, r_col, r_chn;
  logic [W_FRAME_SIZE-1:0] r_data_count;
  logic [W_SIZE:0]         w_chn_sum, w_col_sum, w_row_sum;
  logic                    w_last_grp, w_last_col, w_last_row;

  // Sums carry one extra bit so the last-position compare never sees a wrapped value.
  assign w_chn_sum  = {1'b0, r_chn} + CH_INC;
  assign w_col_sum  = {1'b0, r_col} + {1'b0, i_step_x};
  assign w_row_sum  = {1'b0, r_row} + {1'b0, i_step_y};
  assign w_last_grp = (w_chn_sum == {1'b0, i_channel});
  assign w_last_col = (w_col_sum == {1'b0, i_width});
  assign w_last_row = (w_row_sum == {1'b0, i_height});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_chn        <= '0;
      r_data_count <= '0;
    end else if (i_clear) begin
      r_row        <= '0;
      r_col        <= '0;
      r_chn        <= '0;
      r_data_count <= '0;
    end else if (i_adv) begin
      if (w_last_grp) begin
        r_chn <= '0;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : w_row_sum[W_SIZE-1:0];
        end else begin
          r_col <= w_col_sum[W_SIZE-1:0];
        end
      end else begin
        r_chn <= w_chn_sum[W_SIZE-1:0];
      end
      if (o_end_frame) begin
        r_data_count <= '0;
      end else if (w_last_grp) begin
        r_data_count <= r_data_count + W_FRAME_SIZE'(1);
      end
    end
  end

  assign o_row        = r_row;
  assign o_col        = r_col;
  assign o_chn        = r_chn;
  assign o_data_count = r_data_count;
  assign o_end_line   = w_last_grp & w_last_col;
  assign o_end_frame  = w_last_grp & w_last_col & w_last_row;

endmodule

// File: rtl/res_scan_ctrl.sv
// Layer scan controller: VSYNC, per-line HSYNC and stallable DATA phases over
// a shadowed feature-map configuration, repeated for a batch of frames.
module res_scan_ctrl
  import res_scan_pkg::*;
#(
  parameter int W_SIZE       = 8,
  parameter int W_DELAY      = 12,
  parameter int W_FRAME_SIZE = 2*W_SIZE+3,
  parameter int N_CH_PAR     = 1,
  parameter int W_NFRM       = 8
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_SIZE-1:0]       q_channel,
  input  logic [W_SIZE-1:0]       q_step_x,
  input  logic [W_SIZE-1:0]       q_step_y,
  input  logic [W_DELAY-1:0]      q_vsync_delay,
  input  logic [W_DELAY-1:0]      q_hsync_delay,
  input  logic [W_NFRM-1:0]       q_num_frames,
  input  logic                    q_start,
  input  logic                    q_stop,
  input  logic                    i_ready,
  output logic                    o_ctrl_vsync_run,
  output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
  output logic                    o_ctrl_hsync_run,
  output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
  output logic                    o_ctrl_data_run,
  output logic                    o_beat,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_SIZE-1:0]       o_chn,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic [W_NFRM-1:0]       o_frame_idx,
  output logic                    o_end_line,
  output logic                    o_end_frame,
  output logic                    o_done,
  output logic                    o_cfg_err
);

  scan_state_t        r_state, w_next;
  logic [W_SIZE-1:0]  r_width, r_height, r_channel, r_step_x, r_step_y;
  logic [W_DELAY-1:0] r_vsync_delay, r_hsync_delay, r_vsync_cnt, r_hsync_cnt;
  logic [W_NFRM-1:0]  r_num_frames, r_frame_idx, w_frames_m1;
  logic               r_cfg_err;
  logic               w_legal, w_capture, w_abort, w_accept;
  logic               w_end_line, w_end_frame, w_last_frame;

  // Legality is judged on the live inputs; only a legal start touches the shadow copy.
  assign w_legal      = cfg_legal(32'(q_width), 32'(q_height), 32'(q_channel),
                                  32'(q_step_x), 32'(q_step_y), 32'(N_CH_PAR));
  assign w_capture    = (r_state == ST_IDLE) && q_start && w_legal;
  assign w_abort      = q_stop && (r_state != ST_IDLE);
  assign w_accept     = (r_state == ST_DATA) && i_ready;
  assign w_frames_m1  = (r_num_frames == '0) ? '0 : r_num_frames - W_NFRM'(1);
  assign w_last_frame = (r_frame_idx == w_frames_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_capture) w_next = ST_VSYNC;
      ST_VSYNC: if (r_vsync_cnt == r_vsync_delay) w_next = ST_HSYNC;
      ST_HSYNC: if (r_hsync_cnt == r_hsync_delay) w_next = ST_DATA;
      ST_DATA: begin
        if (i_ready && w_end_line) begin
          if (w_end_frame) begin
            w_next = w_last_frame ? ST_DONE : ST_VSYNC;
          end else begin
            w_next = ST_HSYNC;
          end
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next = ST_IDLE;
    end
  end

  // Counters only survive a cycle that stays in their own state, so they read 0 elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_cnt <= '0;
      r_hsync_cnt <= '0;
    end else begin
      r_vsync_cnt <= (r_state == ST_VSYNC && w_next == ST_VSYNC) ? r_vsync_cnt + W_DELAY'(1) : '0;
      r_hsync_cnt <= (r_state == ST_HSYNC && w_next == ST_HSYNC) ? r_hsync_cnt + W_DELAY'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width       <= '0;
      r_height      <= '0;
      r_channel     <= '0;
      r_step_x      <= '0;
      r_step_y      <= '0;
      r_vsync_delay <= '0;
      r_hsync_delay <= '0;
      r_num_frames  <= '0;
    end else if (w_capture) begin
      r_width       <= q_width;
      r_height      <= q_height;
      r_channel     <= q_channel;
      r_step_x      <= q_step_x;
      r_step_y      <= q_step_y;
      r_vsync_delay <= q_vsync_delay;
      r_hsync_delay <= q_hsync_delay;
      r_num_frames  <= q_num_frames;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_idx <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == ST_IDLE) && q_start && !w_legal;
      if (w_abort || r_state == ST_DONE) begin
        r_frame_idx <= '0;
      end else if (w_accept && w_end_frame && !w_last_frame) begin
        r_frame_idx <= r_frame_idx + W_NFRM'(1);
      end
    end
  end

  res_scan_pos #(
    .W_SIZE       (W_SIZE),
    .W_FRAME_SIZE (W_FRAME_SIZE),
    .N_CH_PAR     (N_CH_PAR)
  ) u_pos (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_abort),
    .i_adv        (w_accept && !w_abort),
    .i_width      (r_width),
    .i_height     (r_height),
    .i_channel    (r_channel),
    .i_step_x     (r_step_x),
    .i_step_y     (r_step_y),
    .o_row        (o_row),
    .o_col        (o_col),
    .o_chn        (o_chn),
    .o_data_count (o_data_count),
    .o_end_line   (w_end_line),
    .o_end_frame  (w_end_frame)
  );

  assign o_ctrl_vsync_run = (r_state == ST_VSYNC);
  assign o_ctrl_hsync_run = (r_state == ST_HSYNC);
  assign o_ctrl_data_run  = (r_state == ST_DATA);
  assign o_ctrl_vsync_cnt = r_vsync_cnt;
  assign o_ctrl_hsync_cnt = r_hsync_cnt;
  assign o_beat           = o_ctrl_data_run & i_ready;
  assign o_end_line       = o_ctrl_data_run & w_end_line;
  assign o_end_frame      = o_ctrl_data_run & w_end_frame;
  assign o_done           = (r_state == ST_DONE);
  assign o_frame_idx      = r_frame_idx;
  assign o_cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_res_scan_ctrl.sv
// Bench for res_scan_ctrl: one instance with one channel per beat and one with
// four, both driven by shared stimulus and checked every cycle against a frame model.
module tb_res_scan_ctrl;

  localparam int PH_IDLE = 0, PH_VS = 1, PH_HS = 2, PH_DATA = 3, PH_DONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  qWidth, qHeight, qChannel, qStepX, qStepY, qFrames;
  logic [11:0] qVsync, qHsync;
  logic        qStart, qStop, iReady;

  logic [1:0]        vRun, hRun, dRun, beat, endLine, endFrame, done, cfgErr;
  logic [1:0][11:0]  vCnt, hCnt;
  logic [1:0][7:0]   row, col, chn, frameIdx;
  logic [1:0][18:0]  dCount;

  res_scan_ctrl #(.N_CH_PAR(1)) u_dut1 (
    .clk(clk), .rst(rst), .q_width(qWidth), .q_height(qHeight), .q_channel(qChannel),
    .q_step_x(qStepX), .q_step_y(qStepY), .q_vsync_delay(qVsync), .q_hsync_delay(qHsync),
    .q_num_frames(qFrames), .q_start(qStart), .q_stop(qStop), .i_ready(iReady),
    .o_ctrl_vsync_run(vRun[0]), .o_ctrl_vsync_cnt(vCnt[0]), .o_ctrl_hsync_run(hRun[0]),
    .o_ctrl_hsync_cnt(hCnt[0]), .o_ctrl_data_run(dRun[0]), .o_beat(beat[0]),
    .o_row(row[0]), .o_col(col[0]), .o_chn(chn[0]), .o_data_count(dCount[0]),
    .o_frame_idx(frameIdx[0]), .o_end_line(endLine[0]), .o_end_frame(endFrame[0]),
    .o_done(done[0]), .o_cfg_err(cfgErr[0])
  );

  res_scan_ctrl #(.N_CH_PAR(4)) u_dut4 (
    .clk(clk), .rst(rst), .q_width(qWidth), .q_height(qHeight), .q_channel(qChannel),
    .q_step_x(qStepX), .q_step_y(qStepY), .q_vsync_delay(qVsync), .q_hsync_delay(qHsync),
    .q_num_frames(qFrames), .q_start(qStart), .q_stop(qStop), .i_ready(iReady),
    .o_ctrl_vsync_run(vRun[1]), .o_ctrl_vsync_cnt(vCnt[1]), .o_ctrl_hsync_run(hRun[1]),
    .o_ctrl_hsync_cnt(hCnt[1]), .o_ctrl_data_run(dRun[1]), .o_beat(beat[1]),
    .o_row(row[1]), .o_col(col[1]), .o_chn(chn[1]), .o_data_count(dCount[1]),
    .o_frame_idx(frameIdx[1]), .o_end_line(endLine[1]), .o_end_frame(endFrame[1]),
    .o_done(done[1]), .o_cfg_err(cfgErr[1])
  );

  int numChecks = 0;
  int numErrors = 0;

  // Model: phase, sync count, beat index within the frame, frame index, shadow config.
  int mPh[2], mCnt[2], mK[2], mFrame[2], mErr[2];
  int mW[2], mH[2], mC[2], mSx[2], mSy[2], mVd[2], mHd[2], mNf[2];

  int doneAt[2], doneCnt[2], vsEnt[2], peak[2], errSeen[2], maxFrame[2];
  int chnMask4;

  task automatic checkOutput(input string name, input int d, input int act, input int exp);
    numChecks++;
    if (act != exp) begin
      numErrors++;
      $display("[TB] FAIL %s dut%0d got %0d expected %0d", name, d, act, exp);
    end
  endtask

  function automatic int ncpOf(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic bit legalModel(input int w, h, c, sx, sy, ncp);
    if (c == 0 || sx == 0 || sy == 0) return 1'b0;
    if (c % ncp != 0) return 1'b0;
    if (w < sx || h < sy) return 1'b0;
    return (w % sx == 0) && (h % sy == 0);
  endfunction

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      mPh[d] = PH_IDLE; mCnt[d] = 0; mK[d] = 0; mFrame[d] = 0; mErr[d] = 0;
      mW[d] = 0; mH[d] = 0; mC[d] = 0; mSx[d] = 0; mSy[d] = 0;
      mVd[d] = 0; mHd[d] = 0; mNf[d] = 0;
    end
  endtask

  task automatic stepModel(input int d);
    int perLine, perFrame, frames;
    bit ok;
    ok = legalModel(int'(qWidth), int'(qHeight), int'(qChannel), int'(qStepX), int'(qStepY), ncpOf(d));
    mErr[d] = 0;
    if (qStop && mPh[d] != PH_IDLE) begin
      mPh[d] = PH_IDLE; mCnt[d] = 0; mK[d] = 0; mFrame[d] = 0;
    end else begin
      case (mPh[d])
        PH_IDLE: if (qStart) begin
          if (ok) begin
            mW[d] = int'(qWidth); mH[d] = int'(qHeight); mC[d] = int'(qChannel);
            mSx[d] = int'(qStepX); mSy[d] = int'(qStepY);
            mVd[d] = int'(qVsync); mHd[d] = int'(qHsync); mNf[d] = int'(qFrames);
            mPh[d] = PH_VS; mCnt[d] = 0;
          end else begin
            mErr[d] = 1;
          end
        end
        PH_VS: if (mCnt[d] == mVd[d]) begin mPh[d] = PH_HS; mCnt[d] = 0; end else mCnt[d]++;
        PH_HS: if (mCnt[d] == mHd[d]) begin mPh[d] = PH_DATA; mCnt[d] = 0; end else mCnt[d]++;
        PH_DATA: if (iReady) begin
          perLine  = (mC[d] / ncpOf(d)) * (mW[d] / mSx[d]);
          perFrame = perLine * (mH[d] / mSy[d]);
          frames   = (mNf[d] == 0) ? 1 : mNf[d];
          mK[d]++;
          if (mK[d] == perFrame) begin
            mK[d] = 0;
            if (mFrame[d] == frames - 1) mPh[d] = PH_DONE;
            else begin mFrame[d]++; mPh[d] = PH_VS; mCnt[d] = 0; end
          end else if (mK[d] % perLine == 0) begin
            mPh[d] = PH_HS; mCnt[d] = 0;
          end
        end
        PH_DONE: begin mPh[d] = PH_IDLE; mFrame[d] = 0; end
        default: mPh[d] = PH_IDLE;
      endcase
    end
  endtask

  task automatic compareDut(input int d);
    int g, nc, nr, k, ph;
    ph = mPh[d];
    k  = mK[d];
    if (mC[d] != 0) begin
      g = mC[d] / ncpOf(d); nc = mW[d] / mSx[d]; nr = mH[d] / mSy[d];
    end else begin
      g = 1; nc = 1; nr = 1;
    end
    checkOutput("vsync_run", d, int'(vRun[d]), int'(ph == PH_VS));
    checkOutput("vsync_cnt", d, int'(vCnt[d]), (ph == PH_VS) ? mCnt[d] : 0);
    checkOutput("hsync_run", d, int'(hRun[d]), int'(ph == PH_HS));
    checkOutput("hsync_cnt", d, int'(hCnt[d]), (ph == PH_HS) ? mCnt[d] : 0);
    checkOutput("data_run", d, int'(dRun[d]), int'(ph == PH_DATA));
    checkOutput("beat", d, int'(beat[d]), int'(ph == PH_DATA && iReady));
    checkOutput("chn", d, int'(chn[d]), (k % g) * ncpOf(d));
    checkOutput("col", d, int'(col[d]), ((k / g) % nc) * mSx[d]);
    checkOutput("row", d, int'(row[d]), (k / (g * nc)) * mSy[d]);
    checkOutput("data_count", d, int'(dCount[d]), k / g);
    checkOutput("frame_idx", d, int'(frameIdx[d]), mFrame[d]);
    checkOutput("end_line", d, int'(endLine[d]), int'(ph == PH_DATA && (k % (g * nc)) == g * nc - 1));
    checkOutput("end_frame", d, int'(endFrame[d]), int'(ph == PH_DATA && k == g * nc * nr - 1));
    checkOutput("done", d, int'(done[d]), int'(ph == PH_DONE));
    checkOutput("cfg_err", d, int'(cfgErr[d]), mErr[d]);
  endtask

  // Inputs change just after posedge, so at negedge they are what the next edge samples.
  always @(negedge clk) begin
    if (rst) resetModel();
    for (int d = 0; d < 2; d++) begin
      compareDut(d);
      if (!rst) stepModel(d);
    end
  end

  task automatic applyStimulus(input int w, h, c, sx, sy, vd, hd, nf);
    qWidth = 8'(w); qHeight = 8'(h); qChannel = 8'(c); qStepX = 8'(sx); qStepY = 8'(sy);
    qVsync = 12'(vd); qHsync = 12'(hd); qFrames = 8'(nf);
  endtask

  // mode 0: ready high, 1: ready on odd cycles, 2: random ready/stop and scrambled config.
  task automatic runAndMeasure(input int mode, input int stopBeat, input int budget);
    int beats0, prevV[2];
    bit finished, stopDone;
    beats0 = 0; finished = 0; stopDone = 0; chnMask4 = 0;
    for (int d = 0; d < 2; d++) begin
      doneAt[d] = 0; doneCnt[d] = 0; vsEnt[d] = 0; peak[d] = 0;
      errSeen[d] = 0; maxFrame[d] = 0; prevV[d] = 0;
    end
    qStart = 1'b1;
    @(posedge clk); #1;
    qStart = 1'b0;
    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      iReady = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 2) == 1) : 1'($urandom_range(0, 1));
      qStop = 1'b0;
      if (stopBeat > 0 && !stopDone && beats0 == stopBeat - 1) begin
        qStop = 1'b1; stopDone = 1;
      end
      if (mode == 2) begin
        qStop = 1'($urandom_range(0, 99) == 0);
        applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 4095),
                      $urandom_range(0, 4095), $urandom_range(0, 255));
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (done[d] && doneAt[d] == 0) doneAt[d] = cyc;
        doneCnt[d] += int'(done[d]);
        if (vRun[d] && prevV[d] == 0) vsEnt[d]++;
        prevV[d] = int'(vRun[d]);
        if (int'(dCount[d]) > peak[d]) peak[d] = int'(dCount[d]);
        if (int'(frameIdx[d]) > maxFrame[d]) maxFrame[d] = int'(frameIdx[d]);
        if (cfgErr[d]) errSeen[d] = 1;
      end
      if (beat[0]) beats0++;
      if (beat[1] && chn[1] < 8'd31) chnMask4 |= (1 << chn[1]);
      if (cyc >= 2 && (vRun | hRun | dRun | done) == 2'b00) finished = 1;
      @(posedge clk); #1;
    end
    qStop = 1'b0;
    iReady = 1'b1;
    if (!finished) checkOutput("run_timeout", 0, 0, 1);
  endtask

  initial begin
    bit seen;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    qStart = 1'b0; qStop = 1'b0; iReady = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_state_runs", 0, int'({vRun, hRun, dRun, done}), 0);
    checkOutput("reset_positions", 0, int'({row[0], col[0], chn[0]}), 0);
    checkOutput("reset_frame_idx", 1, int'(frameIdx[1]), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] base configuration");
    applyStimulus(4, 4, 2, 1, 1, 2, 1, 1);
    runAndMeasure(0, 0, 500);
    checkOutput("base_done_cycle", 0, doneAt[0], 44);
    checkOutput("base_peak_count", 0, peak[0], 15);
    checkOutput("base_done_pulses", 0, doneCnt[0], 1);
    checkOutput("base_vsync_entries", 0, vsEnt[0], 1);
    checkOutput("base_count_after", 0, int'(dCount[0]), 0);
    checkOutput("base_reject_ch2", 1, errSeen[1], 1);
    checkOutput("base_no_run_ch2", 1, doneCnt[1], 0);

    $display("[TB] backpressure");
    runAndMeasure(1, 0, 500);
    checkOutput("bp_done_cycle", 0, doneAt[0], 76);
    checkOutput("bp_peak_count", 0, peak[0], 15);
    checkOutput("bp_done_pulses", 0, doneCnt[0], 1);

    $display("[TB] multi-frame parallel channels");
    applyStimulus(2, 2, 8, 1, 1, 2, 1, 3);
    runAndMeasure(0, 0, 500);
    checkOutput("mf_done_cycle", 1, doneAt[1], 46);
    checkOutput("mf_done_cycle", 0, doneAt[0], 118);
    checkOutput("mf_vsync_entries", 1, vsEnt[1], 3);
    checkOutput("mf_done_pulses", 1, doneCnt[1], 1);
    checkOutput("mf_max_frame", 1, maxFrame[1], 2);
    checkOutput("mf_chn_values", 1, chnMask4, 17);

    $display("[TB] abort");
    applyStimulus(4, 4, 2, 1, 1, 2, 1, 1);
    runAndMeasure(0, 5, 500);
    checkOutput("abort_no_done", 0, doneCnt[0], 0);
    checkOutput("abort_positions", 0, int'({row[0], col[0], chn[0]}), 0);
    checkOutput("abort_count", 0, int'(dCount[0]), 0);
    runAndMeasure(0, 0, 500);
    checkOutput("restart_done_cycle", 0, doneAt[0], 44);

    $display("[TB] illegal configurations");
    applyStimulus(4, 4, 6, 1, 1, 2, 1, 1);
    runAndMeasure(0, 0, 500);
    checkOutput("ch6_reject", 1, errSeen[1], 1);
    checkOutput("ch6_accept", 0, errSeen[0], 0);
    checkOutput("ch6_stay_idle", 1, vsEnt[1], 0);
    applyStimulus(4, 4, 4, 0, 1, 2, 1, 1);
    runAndMeasure(0, 0, 500);
    checkOutput("stepx0_reject", 0, errSeen[0], 1);
    checkOutput("stepx0_reject", 1, errSeen[1], 1);
    checkOutput("stepx0_stay_idle", 0, vsEnt[0] + vsEnt[1], 0);

    $display("[TB] async reset during hsync");
    applyStimulus(4, 4, 2, 1, 1, 2, 1, 1);
    qStart = 1'b1;
    @(posedge clk); #1;
    qStart = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = hRun[0];
    end
    checkOutput("reach_hsync", 0, int'(seen), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("areset_runs", 0, int'({vRun, hRun, dRun, done, beat}), 0);
    checkOutput("areset_counts", 0, int'({vCnt[0], hCnt[0]}), 0);
    checkOutput("areset_positions", 0, int'({row[0], col[0], chn[0]}), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] randomized runs");
    for (int n = 0; n < 12; n++) begin
      applyStimulus($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 8),
                    $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 2));
      runAndMeasure(2, 0, 3000);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

endmodule
